// File: rtl/multi_narrow_pulse_sync.sv
// ============================================================================
// Module   : multi_narrow_pulse_sync
// Purpose  : Multi-channel narrow-pulse capture and clk-domain synchroniser.
//            Each channel latches an asynchronous pulse of any width in a
//            capture flag. The flag crosses into clk through SYNC_STAGES
//            flops, and the channel emits one clk-domain pulse or level per
//            captured event. Also provides busy indication and a sticky
//            stuck-high error per channel.
// Options  : define PULSE_CNT_EN to add per-channel wrapping event counters
//            on the evt_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_narrow_pulse_sync #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_MODE    = 0,
  parameter int STUCK_MAX   = 64,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NUM-1:0]       pulse,
  input  logic [CH_NUM-1:0]       err_clr,
  output logic [CH_NUM-1:0]       sync_pulse,
  output logic [CH_NUM-1:0]       busy,
  output logic [CH_NUM-1:0]       stuck_err
`ifdef PULSE_CNT_EN
  ,
  output logic [CH_NUM*CNT_W-1:0] evt_cnt
`endif
);

  localparam int             STK_W   = $clog2(STUCK_MAX + 1);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(STUCK_MAX);
  // stuck_err is registered, so it is loaded on the edge where stk steps
  // onto STK_MAX, i.e. when the counter currently holds STK_MAX-1 or more.
  localparam logic [STK_W-1:0] STK_LIM = STK_W'(STUCK_MAX - 1);

  genvar g;
  generate
    for (g = 0; g < CH_NUM; g++) begin : g_ch
      logic                   cap_q;
      logic                   cap_clr;
      logic                   cap;
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   lvl;
      logic                   lvl_d;
      logic                   rise;
      logic                   out_d;
      logic                   out_q;
      logic [STK_W-1:0]       stk;
      logic                   stk_set;
      logic                   err_q;

      // The flag is released once the event is seen at the end of the
      // synchroniser and the source has gone low; a high pulse blocks it.
      assign cap_clr = ~rst_n | (sync_q[SYNC_STAGES-1] & ~pulse[g]);

      // Edge-set capture flop: catches pulses narrower than a clk period.
      always_ff @(posedge pulse[g] or posedge cap_clr) begin
        if (cap_clr) cap_q <= 1'b0;
        else         cap_q <= 1'b1;
      end

      // A still-high input counts as captured, so a pulse held across reset
      // release is picked up again without needing a fresh rising edge.
      assign cap = cap_q | pulse[g];

      // Synchroniser chain into the clk domain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], cap};
      end

      assign lvl     = sync_q[SYNC_STAGES-1];
      assign rise    = lvl & ~lvl_d;
      assign out_d   = (OUT_MODE == 0) ? rise : lvl;
      assign stk_set = lvl & (stk >= STK_LIM);

      // Edge register, output register, stuck counter and sticky error.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lvl_d <= 1'b0;
          out_q <= 1'b0;
          stk   <= '0;
          err_q <= 1'b0;
        end else begin
          lvl_d <= lvl;
          out_q <= out_d;
          if (!lvl)              stk <= '0;
          else if (stk != STK_MAX) stk <= stk + 1'b1;
          err_q <= stk_set | (err_q & ~err_clr[g]);
        end
      end

      assign sync_pulse[g] = out_q;
      assign stuck_err[g]  = err_q;
      // Gated by rst_n so a pulse held high during reset does not show busy.
      assign busy[g]       = rst_n & (cap | (|sync_q) | lvl_d);

`ifdef PULSE_CNT_EN
      logic [CNT_W-1:0] cnt;

      // Wrapping count of delivered events.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (rise) cnt <= cnt + 1'b1;
      end

      assign evt_cnt[g*CNT_W +: CNT_W] = cnt;
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_narrow_pulse_sync.sv
// Testbench for multi_narrow_pulse_sync: directed steps with a pulse
// scoreboard (expected mask and cycle queued when a pulse is fired).
`default_nettype none

module tb_multi_narrow_pulse_sync;

  localparam int CH  = 4;
  localparam int CW  = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] pulse   = '0;
  logic [CH-1:0] err_clr = '0;
  logic [CH-1:0] sync_pulse;
  logic [CH-1:0] busy;
  logic [CH-1:0] stuck_err;
`ifdef PULSE_CNT_EN
  logic [CH*CW-1:0] evt_cnt;
`endif

  multi_narrow_pulse_sync #(
    .CH_NUM     (CH),
    .SYNC_STAGES(2),
    .OUT_MODE   (0),
    .STUCK_MAX  (8),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse     (pulse),
    .err_clr   (err_clr),
    .sync_pulse(sync_pulse),
    .busy      (busy),
    .stuck_err (stuck_err)
`ifdef PULSE_CNT_EN
    ,
    .evt_cnt   (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [CH-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt[CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every non-zero output must match the next queued event.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && sync_pulse !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(sync_pulse), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_mask", 32'(sync_pulse), 32'(e.mask));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Fire a pulse 2 ns after a falling edge; output expected 3 edges later.
  task automatic fire(input logic [CH-1:0] m, input int width);
    @(negedge clk);
    #2;
    sb.push_back('{cyc: cyc + 3, mask: m});
    for (int i = 0; i < CH; i++) if (m[i]) exp_cnt[i] = (exp_cnt[i] + 1) % (1 << CW);
    pulse = pulse | m;
    #(width);
    pulse = pulse & ~m;
  endtask

  initial begin : main
    int c0;
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;

    // Reset state
    wait_cyc(3);
    check("rst_sync_pulse", 32'(sync_pulse), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_stuck_err",  32'(stuck_err),  32'd0);
    rst_n = 1'b1;
    wait_cyc(2);
`ifdef PULSE_CNT_EN
    check("rst_evt_cnt", 32'(evt_cnt), 32'd0);
`endif

    // Narrow pulse on ch0 and busy timing
    fire(4'b0001, 2);
    c0 = cyc;
    @(negedge clk);
    check("narrow_busy_set", 32'(busy), 32'b0001);
    wait_cyc(3);
    check("narrow_busy_last", 32'(busy), 32'b0001);
    @(negedge clk);
    check("narrow_busy_clear", 32'(busy), 32'd0);
    wait_cyc(4);

    // Simultaneous events on all channels
    fire(4'b1111, 3);
    wait_cyc(10);

    // Merge on busy: second pulse two cycles later produces nothing new
    fire(4'b0010, 2);
    wait_cyc(2);
    check("merge_busy", 32'(busy[1]), 32'd1);
    #2;
    pulse[1] = 1'b1;
    #2;
    pulse[1] = 1'b0;
    wait_cyc(12);

    // Stuck input on ch2
    @(negedge clk);
    #2;
    c0 = cyc;
    sb.push_back('{cyc: c0 + 3, mask: 4'b0100});
    exp_cnt[2] = (exp_cnt[2] + 1) % (1 << CW);
    pulse[2] = 1'b1;
    while (cyc < c0 + 9) @(negedge clk);
    check("stuck_before", 32'(stuck_err), 32'd0);
    @(negedge clk);
    check("stuck_set", 32'(stuck_err), 32'b0100);
    @(negedge clk);
    #2;
    err_clr[2] = 1'b1;
    @(negedge clk);
    err_clr[2] = 1'b0;
    check("stuck_clr_while_high", 32'(stuck_err), 32'b0100);
    while (cyc < c0 + 20) @(negedge clk);
    #2;
    pulse[2] = 1'b0;
    wait_cyc(5);
    check("stuck_sticky", 32'(stuck_err), 32'b0100);
    check("stuck_busy_done", 32'(busy), 32'd0);
    #2;
    err_clr[2] = 1'b1;
    @(negedge clk);
    err_clr[2] = 1'b0;
    check("stuck_cleared", 32'(stuck_err), 32'd0);
    wait_cyc(4);

    // Reset while a ch3 event is in flight
    @(negedge clk);
    #2;
    pulse[3] = 1'b1;
    #2;
    pulse[3] = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #3;
    check("midrst_sync_pulse", 32'(sync_pulse), 32'd0);
    check("midrst_busy",       32'(busy),       32'd0);
    check("midrst_stuck_err",  32'(stuck_err),  32'd0);
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(6);
    fire(4'b1000, 3);
    wait_cyc(8);

    // Counter wrap: 17 spaced pulses on ch0
    for (int k = 0; k < 17; k++) begin
      fire(4'b0001, 2);
      wait_cyc(8);
    end
    wait_cyc(4);

`ifdef PULSE_CNT_EN
    for (int i = 0; i < CH; i++)
      check("evt_cnt", 32'(evt_cnt[i*CW +: CW]), 32'(exp_cnt[i]));
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
